player_feedback_driver: RTL and testbench
=========================================

// Module: player_feedback_driver
// PURPOSE
//   Output-side counterpart of the player input path: turns game-engine events
//   into player feedback. P1 gets an onboard LED (active low), P2 a GPIO LED
//   (active high), and both share a GPIO buzzer. It runs in the clk_game domain
//   and is driven by the game FSM's one-cycle hit and KO pulses.
// PARAMETERS
//   CNT_W        8   width of every internal counter; all cycle params <= 2**CNT_W-1
//   FLASH_CYCLES 8   LED on-time for a hit (cycles, >=1)
//   BLINK_HALF   4   KO blink half-period (cycles, >=1)
//   BLINK_COUNT  3   KO on/off blink pairs before steady hold (>=1)
//   BUZZ_CYCLES  16  buzzer duration for a hit; a KO uses 4*BUZZ_CYCLES (>=1)
//   TONE_HALF    2   buzzer square-wave half-period (cycles, >=1)
// PORTS
//   clk_game     in   1  game clock, the only clock
//   reset_n      in   1  synchronous, active-low reset
//   p1_hit       in   1  one-cycle pulse: P1 took a hit
//   p2_hit       in   1  one-cycle pulse: P2 took a hit
//   p1_ko        in   1  one-cycle pulse: P1 knocked out
//   p2_ko        in   1  one-cycle pulse: P2 knocked out
//   led_p1_n     out  1  P1 onboard LED, active low
//   gpio_p2_led  out  1  P2 GPIO LED, active high
//   gpio_buzzer  out  1  shared buzzer drive, active high
//   busy_p1      out  1  P1 channel in FLASH or BLINK
//   busy_p2      out  1  P2 channel in FLASH or BLINK
// BEHAVIOUR
//   - Reset and decision: one clock; reset is synchronous and active-low. All
//     outputs are registered. Inputs sampled in cycle N take effect on the
//     outputs in cycle N+1.
//   - Reset values: led_p1_n=1, gpio_p2_led=0, gpio_buzzer=0, busy_p1=busy_p2=0.
//     All FSMs go to IDLE and all counters clear. Reset mid-sequence aborts it.
//   - Per-player FSM, two identical instances: IDLE, FLASH, BLINK_ON,
//     BLINK_OFF, HOLD. LED is lit in FLASH, BLINK_ON and HOLD.
//   - Hit in IDLE -> FLASH. LED stays lit exactly FLASH_CYCLES cycles, then IDLE.
//   - Hit while in FLASH restarts the full FLASH_CYCLES window.
//   - KO in IDLE or FLASH -> BLINK_ON.
//   - KO beats a hit on the same cycle.
//   - Blink sequence: BLINK_ON for BLINK_HALF cycles, then BLINK_OFF for
//     BLINK_HALF cycles. After BLINK_COUNT pairs -> HOLD.
//   - HOLD keeps the LED lit until reset.
//   - Hits and KOs are ignored in BLINK_ON, BLINK_OFF and HOLD.
//   - busy_px=1 in FLASH, BLINK_ON and BLINK_OFF; 0 in IDLE and HOLD.
//   - Buzzer: a remaining-time counter plus a tone divider.
//     - Any hit (p1_hit|p2_hit) reloads remaining := BUZZ_CYCLES.
//     - Any KO reloads remaining := 4*BUZZ_CYCLES, width CNT_W+2.
//     - KO load beats hit load. A reload overwrites time still remaining.
//     - On each reload the tone phase resets: gpio_buzzer=1 on the first
//       active cycle, then toggles every TONE_HALF cycles.
//     - gpio_buzzer=0 whenever remaining==0.
//   - Buzzer events are accepted even when the player's own FSM ignores them,
//     so a hit during BLINK still buzzes.
//   - Simultaneous events on both players: each channel handles its own event
//     independently; the buzzer takes a single reload.
// TESTING
//   1. Release reset_n, idle for 20 cycles -> led_p1_n=1, gpio_p2_led=0,
//      gpio_buzzer=0, busy=0 throughout.
//   2. p1_hit at cycle 10 -> led_p1_n=0 and busy_p1=1 for cycles 11-18, back to
//      1/0 at 19. gpio_buzzer pattern 1,1,0,0 repeating over cycles 11-26, 0 from 27.
//   3. p2_hit at cycle 10, again at 15 -> gpio_p2_led high for cycles 11-23
//      (retrigger). Buzzer phase restarts at 16.
//   4. p1_ko at cycle 5 -> led_p1_n pattern 0000_1111 x3 over cycles 6-29, then
//      0 from 30 onward. busy_p1 falls at 30. Buzzer active cycles 6-69.
//   5. p2_hit and p2_ko in the same cycle -> KO blink sequence, 64-cycle buzz.
//      A later p2_hit during HOLD leaves the LED unchanged but reloads 16 buzz cycles.
//   6. Drop reset_n for 1 cycle mid-blink (cycle 12 of test 4) -> all outputs
//      return to reset values the next cycle; a new p1_hit then flashes normally.

Source files
------------

// File: rtl/player_feedback_driver.sv
// Player feedback driver: turns one-cycle game-engine hit/KO pulses into
// per-player LED sequences (flash on hit, blink-then-hold on KO) and a shared
// buzzer tone whose duration depends on the event type.

// One player's LED sequencer: IDLE -> FLASH on a hit, BLINK_ON/BLINK_OFF pairs
// then a latched HOLD on a KO. The LED level and busy flag are registered.
module player_feedback_channel #(
    parameter int CNT_W          = 8,
    parameter int FLASH_CYCLES   = 8,
    parameter int BLINK_HALF     = 4,
    parameter int BLINK_COUNT    = 3,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic clk_game,
    input  logic reset_n,
    input  logic hit,
    input  logic ko,
    output logic led,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        FLASH,
        BLINK_ON,
        BLINK_OFF,
        HOLD
    } chan_state_t;

    localparam logic LED_ON  = !LED_ACTIVE_LOW;
    localparam logic LED_OFF = LED_ACTIVE_LOW;

    // Counters are loaded with "cycles - 1" so a zero count marks the last
    // cycle of the current phase.
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] PAIR_LAST  = CNT_W'(BLINK_COUNT - 1);

    chan_state_t      state;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] pair_cnt;

    // Sequencer state, phase/pair counters and the registered LED/busy outputs.
    always_ff @(posedge clk_game) begin
        if (!reset_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            pair_cnt  <= '0;
            led       <= LED_OFF;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, FLASH: begin
                    if (ko) begin
                        state     <= BLINK_ON;
                        phase_cnt <= HALF_LAST;
                        pair_cnt  <= '0;
                        led       <= LED_ON;
                        busy      <= 1'b1;
                    end else if (hit) begin
                        state     <= FLASH;
                        phase_cnt <= FLASH_LAST;
                        led       <= LED_ON;
                        busy      <= 1'b1;
                    end else if (state == FLASH) begin
                        if (phase_cnt == '0) begin
                            state <= IDLE;
                            led   <= LED_OFF;
                            busy  <= 1'b0;
                        end else begin
                            phase_cnt <= phase_cnt - CNT_W'(1);
                        end
                    end
                end
                BLINK_ON: begin
                    if (phase_cnt == '0) begin
                        state     <= BLINK_OFF;
                        phase_cnt <= HALF_LAST;
                        led       <= LED_OFF;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end
                BLINK_OFF: begin
                    if (phase_cnt == '0) begin
                        if (pair_cnt == PAIR_LAST) begin
                            state <= HOLD;
                            led   <= LED_ON;
                            busy  <= 1'b0;
                        end else begin
                            state     <= BLINK_ON;
                            phase_cnt <= HALF_LAST;
                            pair_cnt  <= pair_cnt + CNT_W'(1);
                            led       <= LED_ON;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    state <= HOLD;
                end
                default: begin
                    state <= IDLE;
                    led   <= LED_OFF;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

module player_feedback_driver #(
    parameter int CNT_W        = 8,
    parameter int FLASH_CYCLES = 8,
    parameter int BLINK_HALF   = 4,
    parameter int BLINK_COUNT  = 3,
    parameter int BUZZ_CYCLES  = 16,
    parameter int TONE_HALF    = 2
) (
    input  logic clk_game,
    input  logic reset_n,
    input  logic p1_hit,
    input  logic p2_hit,
    input  logic p1_ko,
    input  logic p2_ko,
    output logic led_p1_n,
    output logic gpio_p2_led,
    output logic gpio_buzzer,
    output logic busy_p1,
    output logic busy_p2
);

    // The KO buzz is four times the hit buzz, so the remaining-time counter
    // needs two extra bits beyond the common counter width.
    localparam int REM_W = CNT_W + 2;
    localparam logic [REM_W-1:0] HIT_LOAD  = REM_W'(BUZZ_CYCLES);
    localparam logic [REM_W-1:0] KO_LOAD   = REM_W'(4 * BUZZ_CYCLES);
    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_HALF - 1);

    logic             any_hit;
    logic             any_ko;
    logic [REM_W-1:0] remaining;
    logic [CNT_W-1:0] tone_cnt;

    assign any_hit = p1_hit | p2_hit;
    assign any_ko  = p1_ko | p2_ko;

    // P1 drives the onboard LED, which is wired active low.
    player_feedback_channel #(
        .CNT_W          (CNT_W),
        .FLASH_CYCLES   (FLASH_CYCLES),
        .BLINK_HALF     (BLINK_HALF),
        .BLINK_COUNT    (BLINK_COUNT),
        .LED_ACTIVE_LOW (1'b1)
    ) u_chan_p1 (
        .clk_game (clk_game),
        .reset_n  (reset_n),
        .hit      (p1_hit),
        .ko       (p1_ko),
        .led      (led_p1_n),
        .busy     (busy_p1)
    );

    // P2 drives an external GPIO LED, active high.
    player_feedback_channel #(
        .CNT_W          (CNT_W),
        .FLASH_CYCLES   (FLASH_CYCLES),
        .BLINK_HALF     (BLINK_HALF),
        .BLINK_COUNT    (BLINK_COUNT),
        .LED_ACTIVE_LOW (1'b0)
    ) u_chan_p2 (
        .clk_game (clk_game),
        .reset_n  (reset_n),
        .hit      (p2_hit),
        .ko       (p2_ko),
        .led      (gpio_p2_led),
        .busy     (busy_p2)
    );

    // Shared buzzer: 'remaining' counts active cycles including the current
    // one; any event reloads it and restarts the tone phase high.
    always_ff @(posedge clk_game) begin
        if (!reset_n) begin
            remaining   <= '0;
            tone_cnt    <= '0;
            gpio_buzzer <= 1'b0;
        end else if (any_ko || any_hit) begin
            remaining   <= any_ko ? KO_LOAD : HIT_LOAD;
            tone_cnt    <= TONE_LAST;
            gpio_buzzer <= 1'b1;
        end else if (remaining > REM_W'(1)) begin
            remaining <= remaining - REM_W'(1);
            if (tone_cnt == '0) begin
                gpio_buzzer <= ~gpio_buzzer;
                tone_cnt    <= TONE_LAST;
            end else begin
                tone_cnt <= tone_cnt - CNT_W'(1);
            end
        end else begin
            remaining   <= '0;
            tone_cnt    <= '0;
            gpio_buzzer <= 1'b0;
        end
    end

endmodule

// File: tb/tb_player_feedback_driver.sv
// Testbench for player_feedback_driver: directed scenarios with literal
// expectations plus randomized event traffic checked every cycle against a
// timestamp-based model of the LED and buzzer behaviour.
module tb_player_feedback_driver;

    localparam int CNT_W        = 8;
    localparam int FLASH_CYCLES = 8;
    localparam int BLINK_HALF   = 4;
    localparam int BLINK_COUNT  = 3;
    localparam int BUZZ_CYCLES  = 16;
    localparam int TONE_HALF    = 2;
    localparam int NONE         = -1000000;

    logic clk_game    = 1'b0;
    logic reset_n     = 1'b0;
    logic p1_hit      = 1'b0;
    logic p2_hit      = 1'b0;
    logic p1_ko       = 1'b0;
    logic p2_ko       = 1'b0;
    logic led_p1_n;
    logic gpio_p2_led;
    logic gpio_buzzer;
    logic busy_p1;
    logic busy_p2;

    int total = 0;
    int bad   = 0;

    player_feedback_driver #(
        .CNT_W        (CNT_W),
        .FLASH_CYCLES (FLASH_CYCLES),
        .BLINK_HALF   (BLINK_HALF),
        .BLINK_COUNT  (BLINK_COUNT),
        .BUZZ_CYCLES  (BUZZ_CYCLES),
        .TONE_HALF    (TONE_HALF)
    ) dut (
        .clk_game    (clk_game),
        .reset_n     (reset_n),
        .p1_hit      (p1_hit),
        .p2_hit      (p2_hit),
        .p1_ko       (p1_ko),
        .p2_ko       (p2_ko),
        .led_p1_n    (led_p1_n),
        .gpio_p2_led (gpio_p2_led),
        .gpio_buzzer (gpio_buzzer),
        .busy_p1     (busy_p1),
        .busy_p2     (busy_p2)
    );

    // Free-running game clock.
    always #5 clk_game = ~clk_game;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle's inputs shortly after the rising edge; on return the
    // DUT outputs reflect the new cycle (the previous call's inputs).
    task automatic applyStimulus(input logic rn, input logic h1, input logic h2,
                                 input logic k1, input logic k2);
        @(posedge clk_game);
        #2;
        reset_n = rn;
        p1_hit  = h1;
        p2_hit  = h2;
        p1_ko   = k1;
        p2_ko   = k2;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- behavioural model ----------------
    // Each player remembers whether it was knocked out and the cycle of its
    // last accepted event; outputs follow from elapsed time.
    function automatic void expectChannel(input bit is_ko, input int ev, input int t,
                                          output logic lit, output logic busy);
        int e;
        lit  = 1'b0;
        busy = 1'b0;
        if (is_ko) begin
            e = t - ev - 1;
            if (e < 2 * BLINK_HALF * BLINK_COUNT) begin
                lit  = ((e / BLINK_HALF) % 2) == 0;
                busy = 1'b1;
            end else begin
                lit  = 1'b1;
                busy = 1'b0;
            end
        end else if (ev != NONE && (t - ev) >= 1 && (t - ev) <= FLASH_CYCLES) begin
            lit  = 1'b1;
            busy = 1'b1;
        end
    endfunction

    function automatic logic expectBuzz(input int t, input int bs, input int bl);
        int e;
        if (bl == 0) return 1'b0;
        e = t - bs - 1;
        if (e >= 0 && e < bl) return ((e / TONE_HALF) % 2) == 0;
        return 1'b0;
    endfunction

    // Compare process: on each falling edge check this cycle's outputs against
    // the model, then fold this cycle's inputs into the model.
    initial begin
        int   cyc;
        bit   m_valid;
        bit   m_ko [2];
        int   m_ev [2];
        int   b_start;
        int   b_len;
        logic l1, bz1, l2, bz2, bzz;
        cyc = 0; m_valid = 0;
        m_ko[0] = 0; m_ko[1] = 0; m_ev[0] = NONE; m_ev[1] = NONE;
        b_start = NONE; b_len = 0;
        forever begin
            @(negedge clk_game);
            if (m_valid) begin
                expectChannel(m_ko[0], m_ev[0], cyc, l1, bz1);
                expectChannel(m_ko[1], m_ev[1], cyc, l2, bz2);
                bzz = expectBuzz(cyc, b_start, b_len);
                checkOutput("model led_p1_n", led_p1_n, ~l1);
                checkOutput("model busy_p1", busy_p1, bz1);
                checkOutput("model gpio_p2_led", gpio_p2_led, l2);
                checkOutput("model busy_p2", busy_p2, bz2);
                checkOutput("model gpio_buzzer", gpio_buzzer, bzz);
            end
            if (reset_n !== 1'b1) begin
                m_valid = 1;
                m_ko[0] = 0; m_ko[1] = 0;
                m_ev[0] = NONE; m_ev[1] = NONE;
                b_start = NONE; b_len = 0;
            end else begin
                if (!m_ko[0]) begin
                    if (p1_ko) begin m_ko[0] = 1; m_ev[0] = cyc; end
                    else if (p1_hit) m_ev[0] = cyc;
                end
                if (!m_ko[1]) begin
                    if (p2_ko) begin m_ko[1] = 1; m_ev[1] = cyc; end
                    else if (p2_hit) m_ev[1] = cyc;
                end
                if (p1_ko || p2_ko) begin
                    b_start = cyc; b_len = 4 * BUZZ_CYCLES;
                end else if (p1_hit || p2_hit) begin
                    b_start = cyc; b_len = BUZZ_CYCLES;
                end
            end
            cyc++;
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [1:20] buzz_pat;
        logic [1:24] blink_p1_n;
        buzz_pat   = 20'b1100_1100_1100_1100_0000;
        blink_p1_n = 24'b0000_1111_0000_1111_0000_1111;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Idle after reset: everything quiet.
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("idle led_p1_n", led_p1_n, 1'b1);
            checkOutput("idle gpio_p2_led", gpio_p2_led, 1'b0);
            checkOutput("idle gpio_buzzer", gpio_buzzer, 1'b0);
            checkOutput("idle busy_p1", busy_p1, 1'b0);
            checkOutput("idle busy_p2", busy_p2, 1'b0);
        end

        // P1 hit: 8-cycle flash, 16-cycle 1100 buzz.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("hit led_p1_n", led_p1_n, (k <= 8) ? 1'b0 : 1'b1);
            checkOutput("hit busy_p1", busy_p1, (k <= 8) ? 1'b1 : 1'b0);
            checkOutput("hit gpio_buzzer", gpio_buzzer, buzz_pat[k]);
        end

        // P2 hit retriggered 5 cycles later: window restarts.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("retrig first gpio_p2_led", gpio_p2_led, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("retrig mid gpio_p2_led", gpio_p2_led, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("retrig gpio_p2_led", gpio_p2_led, (k <= 8) ? 1'b1 : 1'b0);
            if (k <= 4) checkOutput("retrig gpio_buzzer", gpio_buzzer, buzz_pat[k]);
        end
        idleCycles(20);

        // P1 KO: three 4/4 blink pairs, then steady hold; 64-cycle buzz.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 70; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("ko led_p1_n", led_p1_n, (k <= 24) ? blink_p1_n[k] : 1'b0);
            checkOutput("ko busy_p1", busy_p1, (k <= 24) ? 1'b1 : 1'b0);
            if (k == 1 || k == 61 || k == 62)
                checkOutput("ko gpio_buzzer on", gpio_buzzer, 1'b1);
            if (k >= 65)
                checkOutput("ko gpio_buzzer off", gpio_buzzer, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("post-hold reset led_p1_n", led_p1_n, 1'b1);
        checkOutput("post-hold reset busy_p1", busy_p1, 1'b0);

        // P2 hit and KO together: KO wins; a later hit in HOLD only buzzes.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 70; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("hitko gpio_p2_led", gpio_p2_led, (k <= 24) ? ~blink_p1_n[k] : 1'b1);
            checkOutput("hitko busy_p2", busy_p2, (k <= 24) ? 1'b1 : 1'b0);
            if (k >= 65) checkOutput("hitko gpio_buzzer off", gpio_buzzer, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("hold hit gpio_p2_led", gpio_p2_led, 1'b1);
            checkOutput("hold hit busy_p2", busy_p2, 1'b0);
            checkOutput("hold hit gpio_buzzer", gpio_buzzer, (k <= 16) ? buzz_pat[k] : 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-blink aborts the sequence; a fresh hit flashes normally.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idleCycles(6);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre-abort led_p1_n", led_p1_n, 1'b1);
        checkOutput("pre-abort busy_p1", busy_p1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("abort led_p1_n", led_p1_n, 1'b1);
        checkOutput("abort busy_p1", busy_p1, 1'b0);
        checkOutput("abort gpio_buzzer", gpio_buzzer, 1'b0);
        checkOutput("abort gpio_p2_led", gpio_p2_led, 1'b0);
        checkOutput("abort busy_p2", busy_p2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rehit led_p1_n", led_p1_n, 1'b0);
        checkOutput("rehit busy_p1", busy_p1, 1'b1);
        checkOutput("rehit gpio_buzzer", gpio_buzzer, 1'b1);

        // Randomized event traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 149) != 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
        end
        idleCycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
